// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   Receive front-end of the UART peripheral. Synchronises the raw serial
//   line, frames 8N1 characters with mid-bit sampling and hands each byte
//   to the register block over a valid/ready handshake.
//
//   Optional feature: define UART_RX_PARITY_EN to add one parity bit after
//   the data bits (PARITY_ODD: 0 = even, 1 = odd). When undefined the
//   PARITY state is unreachable and parity_err is tied low.
//
//   Ports
//     clk            system clock, rising edge
//     rst_n          synchronous active-low reset
//     uart_rx        raw asynchronous serial line, idle high
//     rx_data        received byte, stable while rx_data_valid=1
//     rx_data_valid  byte available, held until accepted
//     rx_data_ready  consumer accepts byte on valid & ready
//     frame_err      one-cycle pulse, stop bit sampled low
//     parity_err     one-cycle pulse, parity mismatch
//     overrun        sticky, a completed byte was dropped (holding reg full)
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | timing to the middle of the start bit
//   DATA   | sampling 8 data bits, LSB first
//   PARITY | sampling the parity bit (parity build only)
//   STOP   | sampling the stop bit, deliver or report error
//   BREAK  | line held low after a framing error, wait for high

module uart_rx_deserializer #(
    parameter int CLK_FREQ   = 27000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int CYCLE = CLK_FREQ / BAUD;
    localparam int CW    = $clog2(CYCLE) + 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(CYCLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CYCLE - 1);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t          state_q, state_d;
    logic            rx_m, rx_s;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_bad_q;
    logic            cnt_zero;
    logic            load_half, load_full, clr_idx, shift_en, par_chk;
    logic            byte_done, frame_bad;
    logic            hs, accept;

    assign cnt_zero = (cnt_q == '0);
    assign hs       = rx_data_valid && rx_data_ready;
    // A full holding register can still take the new byte if it is being
    // emptied by a handshake in the same cycle.
    assign accept   = byte_done && (!rx_data_valid || rx_data_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_half = 1'b0;
        load_full = 1'b0;
        clr_idx   = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    load_half = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        load_full = 1'b1;
                        clr_idx   = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_en  = 1'b1;
                    load_full = 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_zero) begin
                    par_chk   = 1'b1;
                    load_full = 1'b1;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        byte_done = !par_bad_q;
                        state_d   = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
            if (load_half) begin
                cnt_q <= HALF_LOAD;
            end else if (load_full) begin
                cnt_q <= FULL_LOAD;
            end else if (!cnt_zero) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (clr_idx) begin
                bit_idx_q <= '0;
                par_bad_q <= 1'b0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end
            // Shift register already holds the whole byte in PARITY.
            if (par_chk) begin
                par_bad_q <= rx_s != ((^shift_q) ^ (PARITY_ODD != 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            if (accept) begin
                rx_data       <= shift_q;
                rx_data_valid <= 1'b1;
            end else if (hs) begin
                rx_data_valid <= 1'b0;
            end
            // Setting wins over the handshake clear.
            if (byte_done && !accept) begin
                overrun <= 1'b1;
            end else if (hs) begin
                overrun <= 1'b0;
            end
            frame_err <= frame_bad;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (state_q == STOP) && cnt_zero && rx_s && par_bad_q;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
module tb_uart_rx_deserializer;

    localparam int CYCLE = 27000000 / 115200;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // pin edge -> valid rise: 2 sync + 117 + 9*234 + 1 (+234 with parity)
    localparam int LAT = PAR_EN ? 2460 : 2226;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_deserializer #(
        .CLK_FREQ   (27000000),
        .BAUD       (115200),
        .PARITY_ODD (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .overrun       (overrun)
    );

    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_stuck = 0;
    logic [7:0] rx_q[$];
    int         rise_q[$];
    int         start_q[$];
    logic       valid_d = 1'b0;
    logic       ready_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_d = 1'b0;
            ready_d = 1'b0;
        end else begin
            if (rx_data_valid && rx_data_ready) rx_q.push_back(rx_data);
            if (rx_data_valid && !valid_d) rise_q.push_back(cyc);
            if (valid_d && ready_d && rx_data_valid) n_stuck++;
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            valid_d = rx_data_valid;
            ready_d = rx_data_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                              input int stop_len, input logic par_flip);
        start_q.push_back(cyc);
        uart_rx = 1'b0;
        tick(CYCLE);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            tick(CYCLE);
        end
        if (PAR_EN) begin
            uart_rx = (^d) ^ par_flip;
            tick(CYCLE);
        end
        uart_rx = stop_lvl;
        tick(CYCLE * stop_len);
        uart_rx = 1'b1;
    endtask

    task automatic clear_q();
        rx_q.delete();
        rise_q.delete();
        start_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        tick(3);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_valid", rx_data_valid, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst_n = 1'b1;
        rx_data_ready = 1'b1;
        tick(10);

        // back-to-back frames with one idle cycle
        clear_q();
        send_frame(8'h55, 1'b1, 1, 1'b0);
        tick(1);
        send_frame(8'hA3, 1'b1, 1, 1'b0);
        tick(20);
        chk("b2b_count", rx_q.size(), 2);
        chk("b2b_d0", rx_q[0], 8'h55);
        chk("b2b_d1", rx_q[1], 8'hA3);
        chk("b2b_lat0", rise_q[0] - start_q[0], LAT);
        chk("b2b_lat1", rise_q[1] - start_q[1], LAT);
        chk("b2b_ferr", n_ferr, 0);

        // 50-cycle low glitch is a false start
        clear_q();
        uart_rx = 1'b0;
        tick(50);
        uart_rx = 1'b1;
        tick(300);
        chk("glitch_noval", rx_q.size(), 0);
        chk("glitch_ferr", n_ferr, 0);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        tick(20);
        chk("glitch_count", rx_q.size(), 1);
        chk("glitch_d", rx_q[0], 8'h3C);

        // stop bit low for two bit times, then recovery
        clear_q();
        send_frame(8'h7E, 1'b0, 2, 1'b0);
        chk("brk_ferr", n_ferr, 1);
        chk("brk_noval", rx_q.size(), 0);
        tick(10);
        send_frame(8'h81, 1'b1, 1, 1'b0);
        tick(20);
        chk("brk_ferr_once", n_ferr, 1);
        chk("brk_count", rx_q.size(), 1);
        chk("brk_d", rx_q[0], 8'h81);

        // overrun with consumer stalled
        clear_q();
        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1, 1'b0);
        chk("ovr_valid1", rx_data_valid, 1'b1);
        chk("ovr_data1", rx_data, 8'h11);
        chk("ovr_clr1", overrun, 1'b0);
        tick(1);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        tick(5);
        chk("ovr_valid2", rx_data_valid, 1'b1);
        chk("ovr_data2", rx_data, 8'h11);
        chk("ovr_set", overrun, 1'b1);
        rx_data_ready = 1'b1;
        tick(1);
        rx_data_ready = 1'b0;
        chk("ovr_valid_fall", rx_data_valid, 1'b0);
        chk("ovr_cleared", overrun, 1'b0);
        chk("ovr_count", rx_q.size(), 1);
        chk("ovr_d", rx_q[0], 8'h11);
        rx_data_ready = 1'b1;
        tick(10);

        // reset in the middle of data bit 4 of 0xF0
        clear_q();
        uart_rx = 1'b0;
        tick(5 * CYCLE);
        uart_rx = 1'b1;
        tick(CYCLE / 2);
        rst_n = 1'b0;
        tick(1);
        chk("mrst_data", rx_data, 8'h00);
        chk("mrst_valid", rx_data_valid, 1'b0);
        chk("mrst_ovr", overrun, 1'b0);
        chk("mrst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(6 * CYCLE);
        chk("mrst_noval", rx_q.size(), 0);
        chk("mrst_noerr", n_ferr, 1);
        send_frame(8'h0F, 1'b1, 1, 1'b0);
        tick(20);
        chk("mrst_count", rx_q.size(), 1);
        chk("mrst_d", rx_q[0], 8'h0F);

        if (PAR_EN) begin
            clear_q();
            send_frame(8'h07, 1'b1, 1, 1'b0);
            tick(20);
            chk("par_ok_count", rx_q.size(), 1);
            chk("par_ok_d", rx_q[0], 8'h07);
            send_frame(8'h07, 1'b1, 1, 1'b1);
            tick(20);
            chk("par_bad_noval", rx_q.size(), 1);
            chk("par_bad_perr", n_perr, 1);
        end

        chk("perr_total", n_perr, PAR_EN ? 1 : 0);
        chk("valid_held_after_hs", n_stuck, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Receive front-end of the memory-mapped UART peripheral inside Core; upstream of the UART register block.
- Synchronises the raw uart_rx pin and detects 8N1 frames with mid-bit sampling.
- Presents each received byte to the register block over a valid/ready handshake; the register block maps it to rd_data and rx_data_valid.
- Reports framing and overrun errors.

Parameters:
CLK_FREQ, 27000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; derived localparam CYCLE = CLK_FREQ/BAUD (integer division, 234 at defaults), must be >= 4
PARITY_ODD, 0, parity sense when UART_RX_PARITY_EN is defined: 0 = even, 1 = odd

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
uart_rx  input  1  raw asynchronous serial line, idle high
rx_data  output  8  received byte, valid while rx_data_valid=1
rx_data_valid  output  1  byte available; held until accepted
rx_data_ready  input  1  consumer accepts byte when rx_data_valid & rx_data_ready on a rising edge
frame_err  output  1  one-cycle pulse: stop bit sampled low
parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 when feature is compiled out)
overrun  output  1  sticky: a completed frame was dropped because the holding register was full

Behaviour:
- Reset (rst_n=0 at a rising edge): rx_data=0, rx_data_valid=0, frame_err=0, parity_err=0, overrun=0, FSM=IDLE, counter=0, synchroniser flops=1.
- Reset mid-frame aborts the frame; no byte or error is produced.
- Synchroniser: 2-flop chain on uart_rx; all decisions use the second flop, rx_s. This adds 2 cycles of latency to every edge.
- Counter is $clog2(CYCLE)+1 bits and counts down.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: when rx_s=0, load counter with CYCLE/2-1 and go to START.
- START: when counter=0, sample rx_s.
  - rx_s=1: false start; return to IDLE silently.
  - rx_s=0: load CYCLE-1, clear bit index, go to DATA.
- DATA: on each counter=0, shift rx_s into shift register LSB-first and reload CYCLE-1.
  - After bit index 7: go to PARITY if the feature is enabled, else STOP.
- PARITY: on counter=0, compare rx_s to computed parity, latch the mismatch, reload CYCLE-1, go to STOP.
- STOP: on counter=0, sample rx_s.
  - rx_s=1, parity OK: deliver the byte and go to IDLE.
  - rx_s=1, parity mismatch: pulse parity_err for one cycle, discard the byte, go to IDLE.
  - rx_s=0: pulse frame_err for one cycle, discard the byte, go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. No start detection in BREAK.
- Sample points relative to the first cycle rx_s=0 (edge E):
  - start bit at E+CYCLE/2
  - data bit i at E+CYCLE/2+(i+1)*CYCLE
  - stop bit at E+CYCLE/2+9*CYCLE (+CYCLE when parity is enabled)
- Delivery: if holding register empty, or being emptied by a handshake in the same cycle, load rx_data and assert rx_data_valid on the cycle after the stop sample. Otherwise drop the new byte: rx_data is unchanged, overrun is set.
- Simultaneous handshake and delivery in one cycle: the new byte is loaded, rx_data_valid stays 1, no overrun.
- overrun clears on the next successful handshake; if a set and a clear coincide, set wins.
- rx_data_valid falls the cycle after a handshake unless a new byte loads in that same cycle.
- rx_data is stable while rx_data_valid=1.
- A new start bit is accepted in the first cycle IDLE is re-entered; back-to-back frames with no idle gap beyond the stop bit are received.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8 data bits + 1 parity bit (PARITY_ODD selects even/odd); PARITY state active; parity_err pulses on mismatch and the byte is discarded.
- Undefined: 8N1 only; PARITY state unreachable and optimised out; parity_err tied to 0.

Test Plan:
- Send 0x55 then 0xA3 (8N1, CYCLE=234, 1-cycle idle gap), rx_data_ready=1 -> two one-cycle rx_data_valid pulses carrying 0x55 then 0xA3; each valid rises 2+117+9*234+1 cycles after the pin start edge; no errors.
- Low glitch of 50 cycles on uart_rx while idle -> returns to IDLE at the start sample; no valid, no errors; a following 0x3C frame is received correctly.
- Frame 0x7E with stop bit driven low for 2 bit times -> frame_err pulse exactly once, no valid, FSM held in BREAK until line high; next frame 0x81 received.
- rx_data_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held valid, overrun=1 after second stop sample; raise rx_data_ready for one cycle -> valid falls, overrun clears.
- Assert rst_n=0 for 1 cycle in the middle of data bit 4 of 0xF0 -> all outputs 0, no byte delivered; next frame 0x0F received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: send 0x07 with parity bit 1 -> rx_data=0x07 valid; same byte with parity 0 -> parity_err pulse, no valid.
